// File: rtl/matrix_loader_if.sv
// Byte stream handshake feeding matrix_loader.
// Producer drives data/valid; loader answers with ready.
interface matrix_loader_if #(
  parameter int ELEM_WIDTH = 8
);
  logic [ELEM_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/matrix_loader.sv
// Stream-to-matrix loader: takes m, n, then m*n bytes row-major
// and assembles the packed matrix bus for the add stage.
module matrix_loader #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  matrix_loader_if.slave stream,
  output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_out,
  output logic [$clog2(MAX_DIM+1)-1:0] m_out,
  output logic [$clog2(MAX_DIM+1)-1:0] n_out,
  output logic done,
  output logic err
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int CELLS = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [2:0] {
    IDLE,
    GET_M,
    GET_N,
    GET_ELEM,
    DONE,
    ERROR
  } state_t;

  state_t state;

  logic [CELLS-1:0][ELEM_WIDTH-1:0] cells;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic ready_q;
  logic xfer;
  logic byte_ok;
  logic last_col;
  logic last_row;
  logic [IDX_W-1:0] idx;
  logic [DIM_W-1:0] dim_byte;

  assign stream.in_ready = ready_q;
  assign matrix_out = cells;

  assign xfer = stream.in_valid && ready_q;
  assign byte_ok = (stream.in_data != '0) &&
                   (stream.in_data <= ELEM_WIDTH'(MAX_DIM));
  assign dim_byte = stream.in_data[DIM_W-1:0];

  assign last_col = (col == n_out - DIM_W'(1));
  assign last_row = (row == m_out - DIM_W'(1));

  assign idx = IDX_W'(row) * IDX_W'(MAX_DIM) + IDX_W'(col);

  // Load FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cells   <= '0;
      m_out   <= '0;
      n_out   <= '0;
      row     <= '0;
      col     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      ready_q <= 1'b0;
    end else if (start) begin
      // Restart wins over any byte offered in the same cycle.
      state   <= GET_M;
      cells   <= '0;
      m_out   <= '0;
      n_out   <= '0;
      row     <= '0;
      col     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        GET_M: begin
          if (xfer) begin
            if (byte_ok) begin
              m_out <= dim_byte;
              state <= GET_N;
            end else begin
              m_out   <= '0;
              n_out   <= '0;
              cells   <= '0;
              err     <= 1'b1;
              ready_q <= 1'b0;
              state   <= ERROR;
            end
          end
        end
        GET_N: begin
          if (xfer) begin
            if (byte_ok) begin
              n_out <= dim_byte;
              row   <= '0;
              col   <= '0;
              state <= GET_ELEM;
            end else begin
              m_out   <= '0;
              n_out   <= '0;
              cells   <= '0;
              err     <= 1'b1;
              ready_q <= 1'b0;
              state   <= ERROR;
            end
          end
        end
        GET_ELEM: begin
          if (xfer) begin
            cells[idx] <= stream.in_data;
            if (last_col) begin
              col <= '0;
              row <= row + DIM_W'(1);
              if (last_row) begin
                done    <= 1'b1;
                ready_q <= 1'b0;
                state   <= DONE;
              end
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        IDLE, DONE, ERROR: begin
          ready_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
